// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - IF/D request ports and shared memory port bundle
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // instruction-fetch side
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              if_stall;

    // load/store side
    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic              d_stall;

    // single-ported memory
    logic              m_en;
    logic              m_we;
    logic [3:0]        m_be;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    // arbiter view
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata,
        output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
        output m_en, m_we, m_be, m_addr, m_wdata
    );

    // pipeline + memory view
    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata,
        input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
        input  m_en, m_we, m_be, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/D arbiter for one fixed-latency memory port (optional fairness: FAIR_ARB_EN)
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    // Out-of-range latencies fall back to the nearest legal value so the counter never wraps.
    localparam int CNT_W     = 3;
    localparam int LAT_CLAMP = (MEM_LAT < 1) ? 1 : ((MEM_LAT > 7) ? 7 : MEM_LAT);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LAT_CLAMP);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    state_t            state;
    state_t            next_state;
    owner_t            owner;
    logic [CNT_W-1:0]  lat_cnt;

    logic              grant_d;
    logic              grant_if;
    logic              force_if;
    logic              cnt_done;
    logic              if_stall_c;
    logic              d_stall_c;

    logic              m_en_r;
    logic              m_we_r;
    logic [3:0]        m_be_r;
    logic [ADDR_W-1:0] m_addr_r;
    logic [DATA_W-1:0] m_wdata_r;
    logic              if_valid_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic              d_valid_r;
    logic [DATA_W-1:0] d_rdata_r;

    assign cnt_done = (lat_cnt == CNT_W'(1));

`ifdef FAIR_ARB_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_cnt;

    assign force_if = bus.if_req && (starve_cnt == SW'(STARVE_MAX));

    // Count D grants that leave a waiting fetch behind; any IF grant forgives them.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant_if) begin
            starve_cnt <= '0;
        end else if (grant_d && bus.if_req) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end
`else
    assign force_if = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: one access in flight at a time, no arbitration outside IDLE.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (grant_d || grant_if) next_state = S_WAIT;
            S_WAIT: if (cnt_done)            next_state = S_RESP;
            S_RESP:                          next_state = S_IDLE;
            default:                         next_state = S_IDLE;
        endcase
    end

    // Grant decode and stalls: D (older instruction) wins unless the fetch is being starved.
    always_comb begin
        grant_d  = 1'b0;
        grant_if = 1'b0;
        if (state == S_IDLE) begin
            if (bus.d_req && !force_if) begin
                grant_d = 1'b1;
            end else if (bus.if_req) begin
                grant_if = 1'b1;
            end
        end
        if_stall_c = bus.if_req && !if_valid_r;
        d_stall_c  = bus.d_req && !d_valid_r;
    end

    // Datapath: latch the winner onto the memory port, count latency, capture and pulse the response.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_en_r     <= 1'b0;
            m_we_r     <= 1'b0;
            m_be_r     <= 4'h0;
            m_addr_r   <= '0;
            m_wdata_r  <= '0;
            if_valid_r <= 1'b0;
            if_rdata_r <= '0;
            d_valid_r  <= 1'b0;
            d_rdata_r  <= '0;
            lat_cnt    <= '0;
            owner      <= OWN_NONE;
        end else begin
            m_en_r <= 1'b0;
            if (grant_d) begin
                m_en_r    <= 1'b1;
                m_we_r    <= bus.d_we;
                m_be_r    <= bus.d_be;
                m_addr_r  <= bus.d_addr;
                m_wdata_r <= bus.d_wdata;
                owner     <= OWN_D;
                lat_cnt   <= LAT_LOAD;
            end else if (grant_if) begin
                m_en_r    <= 1'b1;
                m_we_r    <= 1'b0;
                m_be_r    <= 4'hF;
                m_addr_r  <= bus.if_addr;
                m_wdata_r <= '0;
                owner     <= OWN_IF;
                lat_cnt   <= LAT_LOAD;
            end

            if (state == S_WAIT) begin
                lat_cnt <= lat_cnt - CNT_W'(1);
                if (cnt_done) begin
                    if (owner == OWN_IF) begin
                        if_rdata_r <= bus.m_rdata;
                        if_valid_r <= 1'b1;
                    end else if (owner == OWN_D) begin
                        d_rdata_r  <= m_we_r ? '0 : bus.m_rdata;
                        d_valid_r  <= 1'b1;
                    end
                end
            end

            // Response data is only visible during the valid pulse.
            if (state == S_RESP) begin
                if_valid_r <= 1'b0;
                if_rdata_r <= '0;
                d_valid_r  <= 1'b0;
                d_rdata_r  <= '0;
                owner      <= OWN_NONE;
            end
        end
    end

    assign bus.m_en     = m_en_r;
    assign bus.m_we     = m_we_r;
    assign bus.m_be     = m_be_r;
    assign bus.m_addr   = m_addr_r;
    assign bus.m_wdata  = m_wdata_r;
    assign bus.if_valid = if_valid_r;
    assign bus.if_rdata = if_rdata_r;
    assign bus.d_valid  = d_valid_r;
    assign bus.d_rdata  = d_rdata_r;
    assign bus.if_stall = if_stall_c;
    assign bus.d_stall  = d_stall_c;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : ~a;
    endfunction

    // memory models: data only valid in the capture cycle (MEM_LAT-1 cycles after the m_en cycle)
    logic [2:0] age_a = 3'd7;
    logic [2:0] age_b = 3'd7;
    always @(posedge clk) begin
        age_a <= bus_a.m_en ? 3'd1 : ((age_a == 3'd7) ? 3'd7 : age_a + 3'd1);
        age_b <= bus_b.m_en ? 3'd1 : ((age_b == 3'd7) ? 3'd7 : age_b + 3'd1);
    end
    assign bus_a.m_rdata = ((bus_a.m_en ? 3'd0 : age_a) == 3'd1) ? memf(bus_a.m_addr) : 32'hBAD0BAD0;
    assign bus_b.m_rdata = ((bus_b.m_en ? 3'd0 : age_b) == 3'd0) ? memf(bus_b.m_addr) : 32'hBAD0BAD0;

    typedef struct {
        logic        rst;
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [3:0]  dbe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        men;
        logic        mwe;
        logic [3:0]  mbe;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic        iv;
        logic [31:0] ird;
        logic        dv;
        logic [31:0] drd;
        logic        istl;
        logic        dstl;
        logic        chkm;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, input logic ir, input logic [31:0] ia,
        input logic dr, input logic dw, input logic [3:0] dbe, input logic [31:0] da, input logic [31:0] dwd,
        input logic men, input logic mwe, input logic [3:0] mbe, input logic [31:0] maddr, input logic [31:0] mwd,
        input logic iv, input logic [31:0] ird, input logic dv, input logic [31:0] drd,
        input logic istl, input logic dstl, input logic chkm);
        vec_t v;
        v.rst = rst; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.dbe = dbe; v.da = da; v.dwd = dwd;
        v.men = men; v.mwe = mwe; v.mbe = mbe; v.maddr = maddr; v.mwd = mwd;
        v.iv = iv; v.ird = ird; v.dv = dv; v.drd = drd; v.istl = istl; v.dstl = dstl; v.chkm = chkm;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [%0d]: got %08h want %08h", name, idx, act, exp);
        end
    endtask

    task automatic chk1(input string name, input int idx, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [%0d]: got %0b want %0b", name, idx, act, exp);
        end
    endtask

    vec_t vecs[$];
    logic found;
    logic exp_is_if;

    initial begin
        bus_a.if_req = 0; bus_a.if_addr = 0; bus_a.d_req = 0; bus_a.d_we = 0;
        bus_a.d_be = 0; bus_a.d_addr = 0; bus_a.d_wdata = 0;
        bus_b.if_req = 0; bus_b.if_addr = 0; bus_b.d_req = 0; bus_b.d_we = 0;
        bus_b.d_be = 0; bus_b.d_addr = 0; bus_b.d_wdata = 0;
        rst_a = 1; rst_b = 1;
        repeat (2) @(posedge clk);

        //                rst ir ia      dr dw dbe   da      dwd      men mwe mbe  maddr   mwd       iv ird           dv drd           is ds chkm
        vecs.push_back(mk(1, 0, 32'h0,   0, 0, 4'h0, 32'h0,  32'h0,    0, 0, 4'h0, 32'h0,  32'h0,    0, 32'h0,        0, 32'h0,        0, 0, 1));
        // plain IF fetch
        vecs.push_back(mk(0, 1, 32'h100, 0, 0, 4'h0, 32'h0,  32'h0,    0, 0, 4'h0, 32'h0,  32'h0,    0, 32'h0,        0, 32'h0,        1, 0, 0));
        vecs.push_back(mk(0, 1, 32'h100, 0, 0, 4'h0, 32'h0,  32'h0,    1, 0, 4'hF, 32'h100,32'h0,    0, 32'h0,        0, 32'h0,        1, 0, 1));
        vecs.push_back(mk(0, 1, 32'h100, 0, 0, 4'h0, 32'h0,  32'h0,    0, 0, 4'h0, 32'h0,  32'h0,    0, 32'h0,        0, 32'h0,        1, 0, 0));
        vecs.push_back(mk(0, 1, 32'h100, 0, 0, 4'h0, 32'h0,  32'h0,    0, 0, 4'h0, 32'h0,  32'h0,    1, 32'hDEADBEEF, 0, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 4'h0, 32'h0,  32'h0,    0, 0, 4'h0, 32'h0,  32'h0,    0, 32'h0,        0, 32'h0,        0, 0, 0));
        // store, rdata forced to 0
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 4'h3, 32'h40, 32'h1234, 0, 0, 4'h0, 32'h0,  32'h0,    0, 32'h0,        0, 32'h0,        0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 4'h3, 32'h40, 32'h1234, 1, 1, 4'h3, 32'h40, 32'h1234, 0, 32'h0,        0, 32'h0,        0, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 4'h3, 32'h40, 32'h1234, 0, 0, 4'h0, 32'h0,  32'h0,    0, 32'h0,        0, 32'h0,        0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 4'h3, 32'h40, 32'h1234, 0, 0, 4'h0, 32'h0,  32'h0,    0, 32'h0,        1, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 4'h0, 32'h0,  32'h0,    0, 0, 4'h0, 32'h0,  32'h0,    0, 32'h0,        0, 32'h0,        0, 0, 0));
        // simultaneous requests: D first, then IF; D address change mid-flight ignored
        vecs.push_back(mk(0, 1, 32'h200, 1, 0, 4'hF, 32'h80, 32'h55,   0, 0, 4'h0, 32'h0,  32'h0,    0, 32'h0,        0, 32'h0,        1, 1, 0));
        vecs.push_back(mk(0, 1, 32'h200, 1, 0, 4'hF, 32'h80, 32'h55,   1, 0, 4'hF, 32'h80, 32'h55,   0, 32'h0,        0, 32'h0,        1, 1, 1));
        vecs.push_back(mk(0, 1, 32'h200, 1, 0, 4'hF, 32'h84, 32'h55,   0, 0, 4'h0, 32'h0,  32'h0,    0, 32'h0,        0, 32'h0,        1, 1, 0));
        vecs.push_back(mk(0, 1, 32'h200, 1, 0, 4'hF, 32'h84, 32'h55,   0, 0, 4'h0, 32'h0,  32'h0,    0, 32'h0,        1, 32'hFFFFFF7F, 1, 0, 0));
        vecs.push_back(mk(0, 1, 32'h200, 0, 0, 4'h0, 32'h0,  32'h0,    0, 0, 4'h0, 32'h0,  32'h0,    0, 32'h0,        0, 32'h0,        1, 0, 0));
        vecs.push_back(mk(0, 1, 32'h200, 0, 0, 4'h0, 32'h0,  32'h0,    1, 0, 4'hF, 32'h200,32'h0,    0, 32'h0,        0, 32'h0,        1, 0, 1));
        vecs.push_back(mk(0, 1, 32'h200, 0, 0, 4'h0, 32'h0,  32'h0,    0, 0, 4'h0, 32'h0,  32'h0,    0, 32'h0,        0, 32'h0,        1, 0, 0));
        vecs.push_back(mk(0, 1, 32'h200, 0, 0, 4'h0, 32'h0,  32'h0,    0, 0, 4'h0, 32'h0,  32'h0,    1, 32'hFFFFFDFF, 0, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 4'h0, 32'h0,  32'h0,    0, 0, 4'h0, 32'h0,  32'h0,    0, 32'h0,        0, 32'h0,        0, 0, 0));
        // IF request dropped mid-transaction still completes
        vecs.push_back(mk(0, 1, 32'h10,  0, 0, 4'h0, 32'h0,  32'h0,    0, 0, 4'h0, 32'h0,  32'h0,    0, 32'h0,        0, 32'h0,        1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 4'h0, 32'h0,  32'h0,    1, 0, 4'hF, 32'h10, 32'h0,    0, 32'h0,        0, 32'h0,        0, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 4'h0, 32'h0,  32'h0,    0, 0, 4'h0, 32'h0,  32'h0,    0, 32'h0,        0, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 4'h0, 32'h0,  32'h0,    0, 0, 4'h0, 32'h0,  32'h0,    1, 32'hFFFFFFEF, 0, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 4'h0, 32'h0,  32'h0,    0, 0, 4'h0, 32'h0,  32'h0,    0, 32'h0,        0, 32'h0,        0, 0, 0));
        // reset during WAIT aborts the load; fresh load afterwards
        vecs.push_back(mk(0, 0, 32'h0,   1, 0, 4'hF, 32'h300,32'h0,    0, 0, 4'h0, 32'h0,  32'h0,    0, 32'h0,        0, 32'h0,        0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 0, 4'hF, 32'h300,32'h0,    1, 0, 4'hF, 32'h300,32'h0,    0, 32'h0,        0, 32'h0,        0, 1, 1));
        vecs.push_back(mk(1, 0, 32'h0,   1, 0, 4'hF, 32'h300,32'h0,    0, 0, 4'h0, 32'h0,  32'h0,    0, 32'h0,        0, 32'h0,        0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 4'h0, 32'h0,  32'h0,    0, 0, 4'h0, 32'h0,  32'h0,    0, 32'h0,        0, 32'h0,        0, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0,   1, 0, 4'hF, 32'h304,32'h0,    0, 0, 4'h0, 32'h0,  32'h0,    0, 32'h0,        0, 32'h0,        0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 0, 4'hF, 32'h304,32'h0,    1, 0, 4'hF, 32'h304,32'h0,    0, 32'h0,        0, 32'h0,        0, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0,   1, 0, 4'hF, 32'h304,32'h0,    0, 0, 4'h0, 32'h0,  32'h0,    0, 32'h0,        0, 32'h0,        0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 0, 4'hF, 32'h304,32'h0,    0, 0, 4'h0, 32'h0,  32'h0,    0, 32'h0,        1, 32'hFFFFFCFB, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 4'h0, 32'h0,  32'h0,    0, 0, 4'h0, 32'h0,  32'h0,    0, 32'h0,        0, 32'h0,        0, 0, 0));

        rst_b = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            rst_a         = vecs[i].rst;
            bus_a.if_req  = vecs[i].ir;
            bus_a.if_addr = vecs[i].ia;
            bus_a.d_req   = vecs[i].dr;
            bus_a.d_we    = vecs[i].dw;
            bus_a.d_be    = vecs[i].dbe;
            bus_a.d_addr  = vecs[i].da;
            bus_a.d_wdata = vecs[i].dwd;
            @(negedge clk);
            chk1("m_en", i, bus_a.m_en, vecs[i].men);
            chk1("if_valid", i, bus_a.if_valid, vecs[i].iv);
            chk("if_rdata", i, bus_a.if_rdata, vecs[i].ird);
            chk1("d_valid", i, bus_a.d_valid, vecs[i].dv);
            chk("d_rdata", i, bus_a.d_rdata, vecs[i].drd);
            chk1("if_stall", i, bus_a.if_stall, vecs[i].istl);
            chk1("d_stall", i, bus_a.d_stall, vecs[i].dstl);
            if (vecs[i].chkm) begin
                chk1("m_we", i, bus_a.m_we, vecs[i].mwe);
                chk("m_be", i, {28'h0, bus_a.m_be}, {28'h0, vecs[i].mbe});
                chk("m_addr", i, bus_a.m_addr, vecs[i].maddr);
                chk("m_wdata", i, bus_a.m_wdata, vecs[i].mwd);
            end
        end

        // both requesters held: observe six grant decisions
        @(posedge clk);
        #1;
        rst_a = 1;
        bus_a.if_req = 0; bus_a.d_req = 0;
        @(posedge clk);
        #1;
        rst_a = 0;
        bus_a.if_req = 1; bus_a.if_addr = 32'h1000;
        bus_a.d_req = 1; bus_a.d_we = 0; bus_a.d_be = 4'hF; bus_a.d_addr = 32'h2000; bus_a.d_wdata = 0;
        for (int g = 0; g < 6; g++) begin
            found = 0;
            for (int k = 0; k < 20 && !found; k++) begin
                @(negedge clk);
                if (bus_a.m_en) found = 1;
            end
`ifdef FAIR_ARB_EN
            exp_is_if = (g == 4);
`else
            exp_is_if = 1'b0;
`endif
            chk1("grant_seen", g, found, 1'b1);
            if (found) chk1("grant_is_if", g, bus_a.m_addr == 32'h1000, exp_is_if);
        end
        @(posedge clk);
        #1;
        bus_a.if_req = 0; bus_a.d_req = 0;

        // MEM_LAT = 1: back-to-back fetches every three cycles
        @(posedge clk);
        #1;
        bus_b.if_req = 1; bus_b.if_addr = 32'h400;
        @(negedge clk);
        for (int c = 0; c < 9; c++) begin
            if (c > 0) @(negedge clk);
            chk1("lat1_m_en", c, bus_b.m_en, (c % 3) == 1);
            chk1("lat1_if_valid", c, bus_b.if_valid, (c % 3) == 2);
            chk1("lat1_if_stall", c, bus_b.if_stall, (c % 3) != 2);
            chk("lat1_if_rdata", c, bus_b.if_rdata, ((c % 3) == 2) ? 32'hFFFFFBFF : 32'h0);
            if ((c % 3) == 1) chk("lat1_m_addr", c, bus_b.m_addr, 32'h400);
        end
        @(posedge clk);
        #1;
        bus_b.if_req = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
